// File: rtl/pwm_from_count.sv
// Registered PWM generator driven by an upstream 4-bit free-running count.
// Define PWM_SEQ_CHECK_EN to add the sticky count-sequence checker (seq_err).
module pwm_from_count (
    input  logic       clk,
    input  logic       rstb,
    input  logic [3:0] count,
    input  logic [4:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm,
    output logic       period_done,
    output logic [7:0] period_cnt,
    output logic       seq_err
);

    logic [4:0] duty_act_q, duty_act_d;
    logic [4:0] duty_pend_q, duty_pend_d;
    logic       pend_q, pend_d;
    logic       pwm_q, pwm_d;
    logic       period_done_q, period_done_d;
    logic [7:0] period_cnt_q, period_cnt_d;
    logic       wrap;
    logic       xfer;
    logic [4:0] duty_clamped;

    assign wrap         = (count == 4'd15);
    assign xfer         = duty_valid && !pend_q;
    assign duty_clamped = (duty_in > 5'd16) ? 5'd16 : duty_in;

    always_comb begin
        duty_act_d    = duty_act_q;
        duty_pend_d   = duty_pend_q;
        pend_d        = pend_q;
        period_cnt_d  = period_cnt_q;
        period_done_d = wrap;
        pwm_d         = ({1'b0, count} < duty_act_q);
        if (wrap) begin
            // A transfer landing on the wrap cycle bypasses the pending slot.
            if (xfer) begin
                duty_act_d = duty_clamped;
            end else if (pend_q) begin
                duty_act_d = duty_pend_q;
            end
            pend_d       = 1'b0;
            period_cnt_d = period_cnt_q + 8'd1;
        end else if (xfer) begin
            duty_pend_d = duty_clamped;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            duty_act_q    <= 5'd0;
            duty_pend_q   <= 5'd0;
            pend_q        <= 1'b0;
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
            period_cnt_q  <= 8'd0;
        end else begin
            duty_act_q    <= duty_act_d;
            duty_pend_q   <= duty_pend_d;
            pend_q        <= pend_d;
            pwm_q         <= pwm_d;
            period_done_q <= period_done_d;
            period_cnt_q  <= period_cnt_d;
        end
    end

    assign duty_ready  = !pend_q;
    assign pwm         = pwm_q;
    assign period_done = period_done_q;
    assign period_cnt  = period_cnt_q;

`ifdef PWM_SEQ_CHECK_EN
    logic [3:0] prev_count_q, prev_count_d;
    logic       prev_vld_q, prev_vld_d;
    logic       seq_err_q, seq_err_d;

    always_comb begin
        prev_count_d = count;
        prev_vld_d   = 1'b1;
        seq_err_d    = seq_err_q;
        // The first sampled cycle after reset has no predecessor to compare with.
        if (prev_vld_q && (count != 4'(prev_count_q + 4'd1))) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prev_count_q <= 4'd0;
            prev_vld_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            prev_count_q <= prev_count_d;
            prev_vld_q   <= prev_vld_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_from_count.sv
// Scoreboard bench for pwm_from_count: the bench plays the upstream counter and
// predicts every registered output from its own cycle model of the block.
module tb_pwm_from_count;

    logic       clk = 1'b0;
    logic       rstb;
    logic [3:0] count;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm;
    logic       period_done;
    logic [7:0] period_cnt;
    logic       seq_err;

    always #5 clk = ~clk;

    pwm_from_count dut (
        .clk        (clk),
        .rstb       (rstb),
        .count      (count),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm        (pwm),
        .period_done(period_done),
        .period_cnt (period_cnt),
        .seq_err    (seq_err)
    );

    typedef struct packed {
        logic       pwm;
        logic       done;
        logic [7:0] cnt;
        logic       ready;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [4:0] m_act;
    logic [4:0] m_pend;
    bit         m_pv;
    logic [7:0] m_cnt;
    bit         m_err;
    bit         m_prev_vld;
    logic [3:0] m_prev;
    int         cnt_r;
    int         hi_cnt;
    int         per_duty;
    bit         per_ok;

`ifdef PWM_SEQ_CHECK_EN
    localparam logic EXP_SEQ_ERR = 1'b1;
`else
    localparam logic EXP_SEQ_ERR = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 5'd0; m_pend = 5'd0; m_pv = 1'b0; m_cnt = 8'd0;
        m_err = 1'b0; m_prev_vld = 1'b0; m_prev = 4'd0;
        cnt_r = 0; hi_cnt = 0; per_duty = 0; per_ok = 1'b0;
    endtask

    // One clock: drive inputs just after an edge, predict, then compare after the next edge.
    task automatic step(input bit v, input logic [4:0] d, output bit acc);
        exp_t       e;
        bit         wrap;
        logic [4:0] cl;
        logic       exp_pwm;
        count      = 4'(cnt_r);
        duty_valid = v;
        duty_in    = d;
        if (cnt_r == 0) begin
            per_duty = int'(m_act); hi_cnt = 0; per_ok = 1'b1;
        end
        acc     = v && !m_pv;
        cl      = (d > 5'd16) ? 5'd16 : d;
        wrap    = (cnt_r == 15);
        exp_pwm = ({1'b0, count} < m_act);
        if (wrap) begin
            if (acc) m_act = cl;
            else if (m_pv) m_act = m_pend;
            m_pv = 1'b0;
            m_cnt = m_cnt + 8'd1;
        end else if (acc) begin
            m_pend = cl; m_pv = 1'b1;
        end
`ifdef PWM_SEQ_CHECK_EN
        if (m_prev_vld && (count != 4'(m_prev + 4'd1))) m_err = 1'b1;
        m_prev = count; m_prev_vld = 1'b1;
`endif
        e.pwm = exp_pwm; e.done = wrap; e.cnt = m_cnt; e.ready = !m_pv; e.err = m_err;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("cyc count=%0d valid=%0b duty=%0d acc=%0b | pwm=%0b done=%0b cnt=%0d ready=%0b err=%0b",
                 count, v, d, acc, pwm, period_done, period_cnt, duty_ready, seq_err);
        check("pwm", pwm, e.pwm);
        check("period_done", period_done, e.done);
        check("period_cnt", period_cnt, e.cnt);
        check("duty_ready", duty_ready, e.ready);
        check("seq_err", seq_err, e.err);
        if (pwm === 1'b1) hi_cnt++;
        if (period_done === 1'b1 && per_ok) begin
            check("hi_cycles", hi_cnt, per_duty);
            per_ok = 1'b0;
        end
        cnt_r = (cnt_r + 1) % 16;
    endtask

    task automatic run(input int n);
        bit a;
        repeat (n) step(1'b0, 5'd0, a);
    endtask

    task automatic run_to(input int c);
        bit a;
        int g = 0;
        while (cnt_r != c && g < 20) begin
            step(1'b0, 5'd0, a);
            g++;
        end
    endtask

    task automatic offer(input logic [4:0] d);
        bit a = 1'b0;
        int g = 0;
        while (!a && g < 40) begin
            step(1'b1, d, a);
            g++;
        end
        duty_valid = 1'b0;
        check("offer_accepted", a, 1);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic do_reset();
        rstb = 1'b0;
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_ready", duty_ready, 1);
        check("rst_period_cnt", period_cnt, 0);
        check("rst_period_done", period_done, 0);
        check("rst_seq_err", seq_err, 0);
        model_reset();
        count = 4'd0; duty_valid = 1'b0; duty_in = 5'd0;
        repeat (2) @(posedge clk);
        #2;
        rstb = 1'b1;
    endtask

    initial begin
        bit a;
        rstb = 1'b1; count = 4'd0; duty_in = 5'd0; duty_valid = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Idle: three periods with zero duty
        run(48);
        check("period_cnt_after_48", period_cnt, 3);

        // Duty 4 offered at count 7
        run_to(7);
        offer(5'd4);
        check("ready_low_after_xfer", duty_ready, 0);
        run(32);

        // Full duty and clamped over-range duty
        offer(5'd16);
        run(36);
        offer(5'd20);
        run(36);

        // Bypass: transfer on the wrap cycle itself
        run_to(15);
        step(1'b1, 5'd8, a);
        duty_valid = 1'b0;
        check("bypass_accepted", a, 1);
        check("bypass_ready", duty_ready, 1);
        run(16);
        check("bypass_ready_after", duty_ready, 1);

        // Illegal step 5 -> 9
        run_to(5);
        step(1'b0, 5'd0, a);
        cnt_r  = 9;
        per_ok = 1'b0;
        step(1'b0, 5'd0, a);
        check("seq_err_after_jump", seq_err, EXP_SEQ_ERR);
        run(20);
        check("seq_err_sticky", seq_err, EXP_SEQ_ERR);

        // Reset at count 10 with duty 12 active and 3 pending
        offer(5'd12);
        run_to(0);
        run_to(2);
        offer(5'd3);
        run_to(10);
        check("pend_before_reset", duty_ready, 0);
        do_reset();
        run(32);
        check("ready_after_reset", duty_ready, 1);
        check("seq_err_after_reset", seq_err, 0);

        if (sb_q.size() != 0) check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_from_count.md
# pwm_from_count

Registered PWM generator that consumes the 4-bit free-running binary count produced by the upstream D-flip-flop counter on the same `clk`/`rstb`. Each 16-cycle count period becomes one PWM period. A programmable duty is loaded through a valid/ready handshake and applied only at period boundaries, so no glitch or partial period is produced. The block also provides a period-done strobe and a completed-period counter, and can optionally check that the incoming count sequence is legal.

## Interface
- No parameters. Widths are fixed by the 4-bit upstream counter.
- Reset: `rstb` is asynchronous and active-low. Clock: `clk`.
- `clk` input 1: rising-edge clock, shared with the upstream counter.
- `rstb` input 1: asynchronous active-low reset, shared with the upstream counter.
- `count` input 4: upstream counter value, nominally +1 mod 16 per clock.
- `duty_in` input 5: requested high-time in cycles per period; legal range 0..16; values above 16 clamp to 16.
- `duty_valid` input 1: `duty_in` is offered this cycle.
- `duty_ready` output 1: block can accept a duty value.
- `pwm` output 1: registered PWM output.
- `period_done` output 1: one-cycle strobe at the end of each period.
- `period_cnt` output 8: number of completed periods, wraps 255→0.
- `seq_err` output 1: sticky error flag for an illegal count step (present only with the macro; see Configuration).

## Operation
- State:
  - `duty_act[4:0]`: active duty.
  - `duty_pend[4:0]` plus `pend`: pending duty and its valid flag.
  - `period_cnt[7:0]`.
  - Optional `prev_count[3:0]` plus `prev_vld`.
- Wrap cycle: any cycle in which the sampled `count` equals 15.
- Handshake:
  - `duty_ready` = !`pend`.
  - A transfer occurs when `duty_valid` and `duty_ready` are both high at a rising edge.
  - On a transfer, the clamped `duty_in` is stored in `duty_pend` and `pend` is set.
- Apply at wrap:
  - If `pend` is set, `duty_act` ← `duty_pend` and `pend` is cleared.
  - If a transfer coincides with the wrap cycle, the clamped `duty_in` is written directly into `duty_act` and `pend` stays 0. The bypass takes priority.
- PWM compare: `pwm` ← (`count` < `duty_act`), using a 5-bit unsigned compare with `count` zero-extended.
  - Duty 0 gives a constant 0.
  - Duty 16 gives a constant 1.
- `period_done` ← 1 for exactly one cycle after each wrap cycle.
- `period_cnt` increments by 1 on each wrap cycle and wraps 255→0.
- `duty_valid` held high while `duty_ready` is low has no effect. The offer is held by the source until accepted.
- Reset values (asynchronous):
  - `pwm`=0, `period_done`=0, `duty_ready`=1.
  - `duty_act`=0, `pend`=0, `period_cnt`=0, `seq_err`=0.
- Reset mid-operation: any pending duty is discarded and the active duty returns to 0. The first period after reset release starts from `count`=0, because the upstream counter shares `rstb`.

## Timing
- `pwm` latency is 1 cycle from `count`: the `pwm` value for count k is visible in the cycle after k is sampled.
- A new duty takes effect on the `pwm` for count 0 of the period following the next wrap cycle. At the output, this is 1 cycle after count 0 is sampled.
- `duty_ready` falls in the cycle after a transfer and rises in the cycle after the wrap that consumes the pending value.
- `period_done` is coincident with the `pwm` bit for count 15.
- `period_cnt` updates on the same edge that raises `period_done`.

## Configuration
- Macro: `PWM_SEQ_CHECK_EN`.
- Defined:
  - `prev_count` ← `count` every cycle.
  - `prev_vld` is set after the first sampled cycle following reset.
  - If `prev_vld` is set and `count` ≠ (`prev_count`+1) mod 16, `seq_err` ← 1 on the next edge.
  - `seq_err` is sticky and cleared only by `rstb`.
  - No check is made on the first cycle after reset.
- Not defined: `seq_err` is tied to 0 and no `prev_count` register exists. All other behaviour is identical.

## Test plan
- Reset, no duty loaded, 48 clocks:
  - `pwm` stays 0.
  - `period_done` pulses every 16 cycles.
  - `period_cnt` reaches 3.
- Offer duty 4 at count 7:
  - `duty_ready` goes low next cycle.
  - The following period shows `pwm` high for exactly 4 cycles (counts 0–3, 1-cycle lag).
  - `duty_ready` goes high after the wrap.
- Offer duty 16, then duty 20:
  - `pwm` is constant 1 for each full period.
  - Duty 20 behaves identically to 16.
- Offer duty 8 exactly at count 15 (bypass case): the very next period has 8 high cycles, and `duty_ready` never drops.
- Force `count` to step 5→9:
  - With `PWM_SEQ_CHECK_EN` defined, `seq_err`=1 on the next cycle and stays 1 until reset.
  - Without the macro, `seq_err` stays 0.
- Assert `rstb` low at count 10 with duty 12 active and duty 3 pending:
  - `pwm`=0, `duty_ready`=1, `period_cnt`=0 immediately.
  - After release, `pwm` stays 0.
